card_reveal_display: RTL

CARD_REVEAL_DISPLAY -- requirements
Module: card_reveal_display

---
 rtl/card_reveal_display.sv | 122 ++++++++++++
 1 files changed

// File: rtl/card_reveal_display.sv
// Card slot display: each slot reveals a loaded card with a dash pattern, then shows its 7-segment glyph.
// Optional CARD_REVEAL_BLINK_EN makes the reveal pattern alternate dash and blank.
module card_reveal_display #(
  parameter int unsigned N_CARDS       = 3,
  parameter int unsigned REVEAL_CYCLES = 4
) (
  input  logic                   slow_clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load_valid,
  input  logic [2:0]             load_slot,
  input  logic [3:0]             load_card,
  output logic                   load_ready,
  output logic                   busy,
  output logic [N_CARDS*7-1:0]   hex
);

  localparam int unsigned CW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT  = CW'(REVEAL_CYCLES - 1);
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    REVEAL = 2'd1,
    SHOWN  = 2'd2
  } slot_state_e;

  slot_state_e           state_q [N_CARDS];
  slot_state_e           state_d [N_CARDS];
  logic [3:0]            card_q  [N_CARDS];
  logic [3:0]            card_d  [N_CARDS];
  logic [CW-1:0]         cnt_q   [N_CARDS];
  logic [CW-1:0]         cnt_d   [N_CARDS];
  logic [N_CARDS*7-1:0]  hex_d;
  logic                  busy_d;
  logic                  accept;

  // Active-low glyph for a shown card; 0 and the invalid codes stay blank.
  function automatic logic [6:0] glyph(input logic [3:0] c);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (c)
      4'd1:    seg = 7'b0001000;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      4'd10:   seg = 7'b1000000;
      4'd11:   seg = 7'b1100001;
      4'd12:   seg = 7'b0011000;
      4'd13:   seg = 7'b0001001;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Only one reveal at a time; clear and reset block new loads.
  assign load_ready = !reset && !clear && !busy;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      for (int i = 0; i < int'(N_CARDS); i++) begin
        state_q[i] <= EMPTY;
        card_q[i]  <= 4'd0;
        cnt_q[i]   <= '0;
      end
      hex  <= '1;
      busy <= 1'b0;
    end else begin
      state_q <= state_d;
      card_q  <= card_d;
      cnt_q   <= cnt_d;
      hex     <= hex_d;
      busy    <= busy_d;
    end
  end

  // Next slot state, then hex/busy decoded from it so outputs line up with the new state.
  always_comb begin
    state_d = state_q;
    card_d  = card_q;
    cnt_d   = cnt_q;
    hex_d   = '1;
    busy_d  = 1'b0;
    for (int i = 0; i < int'(N_CARDS); i++) begin
      if (clear) begin
        state_d[i] = EMPTY;
        card_d[i]  = 4'd0;
        cnt_d[i]   = '0;
      end else begin
        if (state_q[i] == REVEAL) begin
          if (cnt_q[i] == '0) state_d[i] = SHOWN;
          else                cnt_d[i]   = cnt_q[i] - CW'(1);
        end
        if (accept && (load_slot == 3'(i))) begin
          state_d[i] = REVEAL;
          card_d[i]  = load_card;
          cnt_d[i]   = CNT_INIT;
        end
      end

      case (state_d[i])
`ifdef CARD_REVEAL_BLINK_EN
        // Dash on even elapsed reveal cycles, blank on odd.
        REVEAL:  hex_d[7*i +: 7] = (cnt_d[i][0] == CNT_INIT[0]) ? SEG_DASH : SEG_BLANK;
`else
        REVEAL:  hex_d[7*i +: 7] = SEG_DASH;
`endif
        SHOWN:   hex_d[7*i +: 7] = glyph(card_d[i]);
        default: hex_d[7*i +: 7] = SEG_BLANK;
      endcase
      if (state_d[i] == REVEAL) busy_d = 1'b1;
    end
  end

endmodule
